act_skew_feeder: RTL

- Upstream feeder for the left edge of the SIZE x SIZE reduced-precision systolic array.
- Accepts one vector of SIZE signed 8-bit activations per handshake and reduces each lane to the 7-bit array format: the lane's upper 7 bits, with an implied LSB of 1.
- Applies the diagonal skew: row r is delayed r cycles relative to row 0.
- Freezes in lockstep with the array while weights are being loaded.

---
 rtl/act_skew_feeder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/act_skew_feeder.sv
// Left-edge activation feeder for the systolic array: trims each signed 8-bit lane
// to its upper 7 bits and applies the diagonal skew (row r lags row 0 by r cycles).
module act_skew_lane #(
    parameter int DEPTH = 1,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data
);
    logic [DEPTH-1:0][W-1:0] data_pipe;
    logic [DEPTH-1:0]        vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_pipe <= '0;
            vld_pipe  <= '0;
        end else if (en) begin
            data_pipe[0] <= in_data;
            vld_pipe[0]  <= in_vld;
            for (int i = 1; i < DEPTH; i++) begin
                data_pipe[i] <= data_pipe[i-1];
                vld_pipe[i]  <= vld_pipe[i-1];
            end
        end
    end

    assign out_vld  = vld_pipe[DEPTH-1];
    assign out_data = data_pipe[DEPTH-1];
endmodule

module act_skew_feeder #(
    parameter int SIZE       = 8,
    parameter int ACT_WIDTH  = 8,
    parameter int FEED_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SIZE*ACT_WIDTH-1:0]  in_data,
    input  logic                       in_last,
    input  logic                       freeze,
    output logic [SIZE*FEED_WIDTH-1:0] act_out,
    output logic [SIZE-1:0]            act_row_valid,
    output logic                       tile_done,
    output logic                       busy
);
    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            done_n;
    logic            accept;
    logic [SIZE-1:0] lsb_bits;
    logic            unused_lsb;

    assign in_ready = !freeze && (state != DRAIN);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done_n  = 1'b0;
        case (state)
            IDLE, STREAM: begin
                if (accept) begin
                    state_n = in_last ? DRAIN : STREAM;
                    if (in_last) cnt_n = CW'(SIZE);
                end
            end
            DRAIN: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        // Register tile_done so it lines up with the last row's valid of the final vector.
        done_n = (state_n == DRAIN) && (cnt_n == CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            tile_done <= 1'b0;
        end else if (!freeze) begin
            state     <= state_n;
            cnt       <= cnt_n;
            tile_done <= done_n;
        end
    end

    // Lane LSBs are dropped; the array restores an implied 1 in their place.
    for (genvar r = 0; r < SIZE; r++) begin : g_lane
        logic [FEED_WIDTH-1:0] lane_in;
        assign lsb_bits[r] = in_data[r*ACT_WIDTH];
        assign lane_in     = accept ? in_data[r*ACT_WIDTH+1 +: FEED_WIDTH] : '0;

        act_skew_lane #(.DEPTH(r + 1), .W(FEED_WIDTH)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (!freeze),
            .in_vld   (accept),
            .in_data  (lane_in),
            .out_vld  (act_row_valid[r]),
            .out_data (act_out[r*FEED_WIDTH +: FEED_WIDTH])
        );
    end

    assign unused_lsb = ^lsb_bits;
endmodule
